// File: rtl/pic_priority_resolver_if.sv
// 8259 priority-resolver bus: request pins, mode bits, acknowledge/EOI
// strobes in; INT, IRR/ISR readback and vector ID out.
interface pic_priority_resolver_if;
  logic [7:0] ir_in;
  logic       ltim;
  logic [7:0] imr;
  logic       aeoi;
  logic       inta_first;
  logic       inta_second;
  logic       eoi_valid;
  logic       eoi_specific;
  logic [2:0] eoi_level;
  logic       rotate_en;
  logic       int_req;
  logic [7:0] irr;
  logic [7:0] isr;
  logic [2:0] highest_isr;
  logic [2:0] vector_id;
  logic       vector_valid;

  modport master (
    output ir_in, ltim, imr, aeoi,
    output inta_first, inta_second,
    output eoi_valid, eoi_specific, eoi_level,
    output rotate_en,
    input  int_req, irr, isr, highest_isr,
    input  vector_id, vector_valid
  );

  modport slave (
    input  ir_in, ltim, imr, aeoi,
    input  inta_first, inta_second,
    input  eoi_valid, eoi_specific, eoi_level,
    input  rotate_en,
    output int_req, irr, isr, highest_isr,
    output vector_id, vector_valid
  );
endinterface

// File: rtl/pic_priority_resolver.sv
// 8259 IRR/ISR + priority resolver. Ports: clk, rst_n (async low),
// bus (slave): IR pins, mask, modes, INTA/EOI strobes -> INT, IRR, ISR, ID.
module pic_priority_resolver #(
  parameter int         NUM_IR      = 8,
  parameter logic [2:0] SPURIOUS_ID = 3'd7
) (
  input logic                    clk,
  input logic                    rst_n,
  pic_priority_resolver_if.slave bus
);

  logic [NUM_IR-1:0] r_irr;
  logic [NUM_IR-1:0] r_isr;
  logic [NUM_IR-1:0] r_prev;
  logic [2:0]        r_lp;
  logic              r_int;
  logic [2:0]        r_vid;
  logic              r_vv;
  logic              r_spur;

  // {found, index} of the highest-priority set bit; the scan runs
  // lowest->highest priority so the last hit wins.
  function automatic logic [3:0] f_pick(
    input logic [7:0] v,
    input logic [2:0] lp
  );
    logic [2:0] idx;
    f_pick = 4'd0;
    for (int k = 7; k >= 0; k--) begin
      idx = lp + 3'd1 + 3'(k);
      if (v[idx]) f_pick = {1'b1, idx};
    end
  endfunction

  logic [7:0] w_cand;
  logic [3:0] w_win;
  logic [3:0] w_hi;
  logic [2:0] w_win_rank;
  logic [2:0] w_hi_rank;
  logic       w_int;
  logic       w_ack;
  logic [7:0] w_ack_mask;
  logic [2:0] w_eoi_idx;
  logic       w_eoi_hit;
  logic [7:0] w_eoi_mask;
  logic       w_aeoi_hit;
  logic [7:0] w_aeoi_mask;
  logic [7:0] w_irr_cap;

  assign w_cand     = r_irr & ~bus.imr;
  assign w_win      = f_pick(w_cand, r_lp);
  assign w_hi       = f_pick(r_isr, r_lp);
  // rank 0 = highest priority
  assign w_win_rank = w_win[2:0] - r_lp - 3'd1;
  assign w_hi_rank  = w_hi[2:0] - r_lp - 3'd1;
  assign w_int      = w_win[3] & (~w_hi[3] | (w_win_rank < w_hi_rank));

  assign w_ack      = bus.inta_first & w_win[3];
  assign w_ack_mask = w_ack ? (8'd1 << w_win[2:0]) : 8'd0;

  // an empty ISR yields index 0 with r_isr[0]=0, so no hit
  assign w_eoi_idx  = bus.eoi_specific ? bus.eoi_level : w_hi[2:0];
  assign w_eoi_hit  = bus.eoi_valid & r_isr[w_eoi_idx];
  assign w_eoi_mask = w_eoi_hit ? (8'd1 << w_eoi_idx) : 8'd0;

  assign w_aeoi_hit  = bus.inta_second & bus.aeoi & ~r_spur;
  assign w_aeoi_mask = w_aeoi_hit ? (8'd1 << r_vid) : 8'd0;

  assign w_irr_cap = bus.ltim ? bus.ir_in
                              : (r_irr | (bus.ir_in & ~r_prev));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irr  <= '0;
      r_isr  <= '0;
      r_prev <= '0;
      r_lp   <= 3'd7;
      r_int  <= 1'b0;
      r_vid  <= 3'd0;
      r_vv   <= 1'b0;
      r_spur <= 1'b0;
    end else begin
      r_prev <= bus.ir_in;
      r_irr  <= w_irr_cap & ~w_ack_mask;
      r_isr  <= (r_isr & ~w_eoi_mask & ~w_aeoi_mask) | w_ack_mask;
      r_int  <= bus.inta_first ? 1'b0 : w_int;
      r_vv   <= bus.inta_second;
      if (bus.inta_first) begin
        r_vid  <= w_win[3] ? w_win[2:0] : SPURIOUS_ID;
        r_spur <= ~w_win[3];
      end
      // explicit EOI rotation takes precedence over AEOI rotation
      if (bus.rotate_en && w_eoi_hit)
        r_lp <= w_eoi_idx;
      else if (bus.rotate_en && w_aeoi_hit)
        r_lp <= r_vid;
    end
  end

  assign bus.int_req      = r_int;
  assign bus.irr          = r_irr;
  assign bus.isr          = r_isr;
  assign bus.highest_isr  = w_hi[2:0];
  assign bus.vector_id    = r_vid;
  assign bus.vector_valid = r_vv;

endmodule

// File: tb/tb_pic_priority_resolver.sv
// Bench for pic_priority_resolver: priority-list model checked every
// cycle, plus directed vectors with literal expectations.
module tb_pic_priority_resolver;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pic_priority_resolver_if bus();

  pic_priority_resolver dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] m_irr, m_isr, m_prev;
  int         m_lp;
  logic       m_int, m_vv, m_spur;
  logic [2:0] m_vid;

  // walk the priority list from highest to lowest
  function automatic int best(logic [7:0] v, int lp);
    for (int k = 0; k < 8; k++)
      if (v[(lp + 1 + k) % 8]) return (lp + 1 + k) % 8;
    return -1;
  endfunction

  function automatic int rank(int i, int lp);
    return (i - lp - 1 + 16) % 8;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_irr <= 0; m_isr <= 0; m_prev <= 0; m_lp <= 7;
      m_int <= 0; m_vv <= 0; m_vid <= 0; m_spur <= 0;
    end else begin : upd
      int w, hi, e, lpn;
      logic [7:0] irrn, isrn;
      w   = best(m_irr & ~bus.imr, m_lp);
      hi  = best(m_isr, m_lp);
      lpn = m_lp;
      if (bus.ltim) irrn = bus.ir_in;
      else          irrn = m_irr | (bus.ir_in & ~m_prev);
      isrn = m_isr;
      if (bus.inta_second && bus.aeoi && !m_spur) begin
        isrn[m_vid] = 1'b0;
        if (bus.rotate_en) lpn = m_vid;
      end
      if (bus.eoi_valid) begin
        e = bus.eoi_specific ? int'(bus.eoi_level) : hi;
        if (e >= 0 && m_isr[e]) begin
          isrn[e] = 1'b0;
          if (bus.rotate_en) lpn = e;
        end
      end
      if (bus.inta_first && w >= 0) begin
        isrn[w] = 1'b1;
        irrn[w] = 1'b0;
      end
      if (bus.inta_first) begin
        m_vid  <= (w >= 0) ? 3'(w) : 3'd7;
        m_spur <= (w < 0);
      end
      m_int  <= bus.inta_first ? 1'b0 :
                (w >= 0 && (hi < 0 || rank(w, m_lp) < rank(hi, m_lp)));
      m_irr  <= irrn;
      m_isr  <= isrn;
      m_lp   <= lpn;
      m_vv   <= bus.inta_second;
      m_prev <= bus.ir_in;
    end
  end

  // compare every cycle while out of reset
  always @(negedge clk) begin
    if (rst_n) begin : cmp
      int h;
      h = best(m_isr, m_lp);
      chk("int_req", 8'(bus.int_req), 8'(m_int));
      chk("irr", bus.irr, m_irr);
      chk("isr", bus.isr, m_isr);
      chk("highest_isr", 8'(bus.highest_isr), (h < 0) ? 8'd0 : 8'(h));
      chk("vector_id", 8'(bus.vector_id), 8'(m_vid));
      chk("vector_valid", 8'(bus.vector_valid), 8'(m_vv));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic p_first();
    bus.inta_first = 1; cyc(1); bus.inta_first = 0;
  endtask

  task automatic p_second();
    bus.inta_second = 1; cyc(1); bus.inta_second = 0;
  endtask

  task automatic eoi(logic spec, logic [2:0] lvl);
    bus.eoi_valid = 1; bus.eoi_specific = spec; bus.eoi_level = lvl;
    cyc(1);
    bus.eoi_valid = 0; bus.eoi_specific = 0; bus.eoi_level = 0;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_int"}, 8'(bus.int_req), 8'd0);
    chk({tag, "_irr"}, bus.irr, 8'd0);
    chk({tag, "_isr"}, bus.isr, 8'd0);
    chk({tag, "_hi"}, 8'(bus.highest_isr), 8'd0);
    chk({tag, "_vid"}, 8'(bus.vector_id), 8'd0);
    chk({tag, "_vv"}, 8'(bus.vector_valid), 8'd0);
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 0;
    bus.ir_in = 0; bus.ltim = 0; bus.imr = 0; bus.aeoi = 0;
    bus.inta_first = 0; bus.inta_second = 0;
    bus.eoi_valid = 0; bus.eoi_specific = 0; bus.eoi_level = 0;
    bus.rotate_en = 0;
    cyc(2);
    chk_zero("rst");
    rst_n = 1;
    cyc(1);

    // single edge request on IR3
    bus.ir_in = 8'h08; cyc(1);
    chk("t1_irr", bus.irr, 8'h08);
    chk("t1_int0", 8'(bus.int_req), 8'd0);
    bus.ir_in = 0; cyc(1);
    chk("t1_int1", 8'(bus.int_req), 8'd1);
    p_first();
    chk("t1_isr", bus.isr, 8'h08);
    chk("t1_irr0", bus.irr, 8'h00);
    chk("t1_vid", 8'(bus.vector_id), 8'd3);
    chk("t1_intd", 8'(bus.int_req), 8'd0);
    p_second();
    chk("t1_vv", 8'(bus.vector_valid), 8'd1);
    cyc(1);
    chk("t1_vv0", 8'(bus.vector_valid), 8'd0);

    // nesting: IR5 blocked by IR3, IR1 preempts
    bus.ir_in = 8'h20; cyc(2);
    chk("t3_irr", bus.irr, 8'h20);
    chk("t3_int0", 8'(bus.int_req), 8'd0);
    bus.ir_in = 8'h22; cyc(2);
    chk("t3_int1", 8'(bus.int_req), 8'd1);
    p_first();
    chk("t3_vid", 8'(bus.vector_id), 8'd1);
    chk("t3_isr", bus.isr, 8'h0A);
    chk("t3_hi", 8'(bus.highest_isr), 8'd1);
    p_second();
    eoi(0, 0);
    chk("t3_eoi1", bus.isr, 8'h08);
    eoi(0, 0);
    chk("t3_eoi2", bus.isr, 8'h00);
    cyc(1);
    chk("t3_int5", 8'(bus.int_req), 8'd1);
    p_first();
    chk("t3_vid5", 8'(bus.vector_id), 8'd5);
    p_second();
    eoi(1, 3'd5);
    chk("t3_seoi", bus.isr, 8'h00);
    bus.ir_in = 0; cyc(1);

    // simultaneous IR2/IR5
    bus.ir_in = 8'h24; cyc(2);
    chk("t2_int", 8'(bus.int_req), 8'd1);
    p_first();
    chk("t2_vid", 8'(bus.vector_id), 8'd2);
    chk("t2_isr", bus.isr, 8'h04);
    p_second();
    eoi(0, 0);
    chk("t2_isr0", bus.isr, 8'h00);
    cyc(1);
    chk("t2_int5", 8'(bus.int_req), 8'd1);
    p_first();
    chk("t2_vid5", 8'(bus.vector_id), 8'd5);
    p_second();
    eoi(0, 0);
    bus.ir_in = 0; cyc(1);

    // rotation with AEOI
    bus.rotate_en = 1; bus.aeoi = 1;
    bus.ir_in = 8'h04; cyc(2);
    p_first();
    chk("t4_vid2", 8'(bus.vector_id), 8'd2);
    p_second();
    chk("t4_aeoi", bus.isr, 8'h00);
    bus.ir_in = 0; cyc(1);
    bus.ir_in = 8'h12; cyc(2);
    chk("t4_int", 8'(bus.int_req), 8'd1);
    p_first();
    chk("t4_vid4", 8'(bus.vector_id), 8'd4);
    p_second();
    p_first();
    chk("t4_vid1", 8'(bus.vector_id), 8'd1);
    p_second();
    bus.rotate_en = 0; bus.aeoi = 0;
    bus.ir_in = 0; cyc(1);

    // masking
    bus.imr = 8'h01; bus.ir_in = 8'h01; cyc(1);
    chk("t5_irr", bus.irr, 8'h01);
    cyc(1);
    chk("t5_int0", 8'(bus.int_req), 8'd0);
    bus.imr = 0; cyc(1);
    chk("t5_int1", 8'(bus.int_req), 8'd1);
    p_first();
    chk("t5_vid", 8'(bus.vector_id), 8'd0);
    chk("t5_isr", bus.isr, 8'h01);
    p_second();
    bus.ir_in = 0;

    // spurious acknowledge
    p_first();
    chk("t6_vid", 8'(bus.vector_id), 8'd7);
    chk("t6_isr", bus.isr, 8'h01);
    bus.aeoi = 1;
    p_second();
    chk("t6_isr2", bus.isr, 8'h01);
    chk("t6_vv", 8'(bus.vector_valid), 8'd1);
    bus.aeoi = 0;

    // EOI and inta_first in the same cycle
    bus.ir_in = 8'h40; cyc(2);
    chk("t7_int", 8'(bus.int_req), 8'd1);
    bus.inta_first = 1; bus.eoi_valid = 1;
    cyc(1);
    bus.inta_first = 0; bus.eoi_valid = 0;
    chk("t7_isr", bus.isr, 8'h40);
    chk("t7_vid", 8'(bus.vector_id), 8'd6);
    p_second();
    eoi(0, 0);
    chk("t7_isr0", bus.isr, 8'h00);
    bus.ir_in = 0; cyc(1);

    // level mode
    bus.ltim = 1; bus.ir_in = 8'h80; cyc(1);
    chk("t8_irr", bus.irr, 8'h80);
    bus.ir_in = 0; cyc(1);
    chk("t8_irr0", bus.irr, 8'h00);
    bus.ir_in = 8'h80; cyc(2);
    p_first();
    chk("t8_vid", 8'(bus.vector_id), 8'd7);
    chk("t8_isr", bus.isr, 8'h80);

    // reset in the middle of the acknowledge
    bus.inta_second = 1; #2 rst_n = 0; #1;
    chk_zero("mid");
    cyc(1);
    chk("mid_vv", 8'(bus.vector_valid), 8'd0);
    bus.inta_second = 0; bus.ltim = 0; bus.ir_in = 0;
    rst_n = 1;
    cyc(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pic_priority_resolver.md
Name: pic_priority_resolver

Overview:
- Interrupt-request, in-service and priority-resolution stage of the 8259 PIC.
- Sits between the IR pins and the control-logic block, and is fully synchronous to one clock.
- Latches requests into the IRR (edge- or level-triggered) and applies the mask.
- Resolves priority (fully nested, optional rotation) and raises INT.
- Moves the winning request into the ISR on the first INTA.
- Reports the vector ID on the second INTA and clears ISR bits on EOI or AEOI.

Parameters:
- NUM_IR, 8, number of interrupt request lines. Fixed at 8; the vector ID is 3 bits wide.
- SPURIOUS_ID, 3'd7, ID reported when an acknowledge finds no pending request.

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- ir_in  input  8  raw IR0..IR7 request pins, already synchronised
- ltim  input  1  1 = level-triggered, 0 = edge-triggered (ICW1 LTIM)
- imr  input  8  interrupt mask (OCW1); 1 = masked
- aeoi  input  1  automatic EOI mode (ICW4)
- inta_first  input  1  one-cycle pulse marking the first INTA
- inta_second  input  1  one-cycle pulse marking the second INTA
- eoi_valid  input  1  one-cycle pulse requesting an OCW2 EOI
- eoi_specific  input  1  1 = specific EOI, 0 = non-specific EOI
- eoi_level  input  3  IR index cleared by a specific EOI
- rotate_en  input  1  rotate priority when an ISR bit is cleared by EOI or AEOI
- int_req  output  1  INT to the CPU
- irr  output  8  interrupt request register (for OCW3 read)
- isr  output  8  in-service register (for OCW3 read)
- highest_isr  output  3  highest-priority set ISR bit; 0 when the ISR is empty
- vector_id  output  3  ID latched on inta_first
- vector_valid  output  1  one-cycle pulse on the cycle after inta_second

Behaviour:
- Reset (async, rst_n low):
  - irr=0, isr=0, int_req=0, vector_id=0, vector_valid=0.
  - Internal ir_prev=0.
  - lowest_pri=7, so IR0 is highest priority.
- Request capture, every clk:
  - Edge mode: irr[i] sets when ir_prev[i]=0 and ir_in[i]=1. It holds until acknowledged; a low pin does not clear it.
  - Level mode: irr[i] equals ir_in[i] each cycle.
  - In both modes the acknowledge clear overrides for that cycle.
  - ir_prev <= ir_in every cycle.
- Priority order:
  - Starts at (lowest_pri+1) mod 8 and descends to lowest_pri, with wrap-around.
  - Candidate set is irr & ~imr.
- INT:
  - int_req is registered.
  - It is set when a candidate exists whose priority is strictly higher than highest_isr. When isr=0, any candidate qualifies.
  - Latency: 1 clk from irr update to int_req.
  - It deasserts the cycle after inta_first.
- inta_first:
  - Resolve the highest-priority candidate W in that cycle.
  - Next edge: isr[W]<=1, irr[W]<=0, vector_id<=W.
  - If no candidate exists: vector_id<=SPURIOUS_ID, and isr and irr are unchanged.
- inta_second:
  - Next edge: vector_valid<=1 for exactly 1 clk.
  - If aeoi=1: isr[vector_id]<=0, and lowest_pri<=vector_id when rotate_en=1.
  - A spurious acknowledge clears nothing.
- EOI (eoi_valid):
  - Non-specific: clear the highest-priority set ISR bit, using pre-update isr.
  - Specific: clear isr[eoi_level].
  - A clear on an already-zero bit is a no-op.
  - If rotate_en=1 and a bit was cleared, lowest_pri<=the cleared index.
- Simultaneous events:
  - EOI with inta_first in the same cycle: the EOI acts on pre-update isr, and the set of W is also applied.
  - EOI with inta_second+AEOI in the same cycle: both clears apply, and the rotation from EOI wins.
  - A new edge on bit W in the same cycle as its ack: the clear wins.
- Masking:
  - imr does not gate irr capture.
  - A masked bit stays pending and raises INT once it is unmasked.
- Reset mid-acknowledge: all state returns to reset values; no vector_valid is produced.

Test Plan:
- Edge mode, imr=0, pulse ir_in[3] -> irr=0x08 next clk, int_req=1 one clk later; inta_first -> isr=0x08, irr=0, vector_id=3; inta_second -> vector_valid pulse.
- ir_in=0x24 simultaneously, no rotation -> ack gives vector_id=2 and isr=0x04; non-specific EOI -> isr=0, int_req reasserts for IR5.
- isr=0x08 (IR3 in service), raise IR5 -> int_req stays 0; raise IR1 -> int_req=1 (nesting).
- rotate_en=1, aeoi=1, service IR2 -> lowest_pri=2; then ir_in=0x12 -> vector_id=4 wins over IR1.
- imr=0x01, ir_in[0] edge -> irr=0x01 and int_req=0; imr=0 -> int_req=1 one clk later.
- inta_first with no candidate -> vector_id=7, isr unchanged; rst_n low mid-sequence -> all outputs 0.
